ps2_ascii_decoder: RTL and testbench

- Upstream feeder of the text-entry `add` stage.
- Converts PS/2 scan-code set 2 bytes from the keyboard receiver into 8-bit ASCII characters.
- Issues a one-cycle `next` strobe per character and a one-cycle `done` strobe on Enter.
- Tracks shift and caps-lock state; swallows break (key-release) and unsupported sequences.

---
 rtl/ps2_ascii_decoder_pkg.sv | 28 ++
 rtl/ps2_ascii_decoder_if.sv | 19 +
 rtl/ps2_ascii_decoder_scancode_lut.sv | 68 ++++++
 rtl/ps2_ascii_decoder.sv | 105 ++++++++++
 tb/tb_ps2_ascii_decoder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_ascii_decoder_pkg.sv
// Shared scan-code set 2 constants, ASCII constants and FSM state type
// for the PS/2 to ASCII decoder.
package ps2_ascii_decoder_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_SPACE  = 8'h29;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_e;

   function automatic logic [7:0] letter_ascii(input logic [4:0] idx, input logic upper);
      return (upper ? 8'h41 : 8'h61) + {3'b000, idx};
   endfunction

endpackage

// File: rtl/ps2_ascii_decoder_if.sv
// Scan-byte input and character output bundle of the PS/2 ASCII decoder.
interface ps2_ascii_decoder_if;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic [7:0] data_out;
   logic       next;
   logic       done;
   logic       caps_state;

   modport master (
      output scan_code, scan_valid,
      input  data_out, next, done, caps_state
   );

   modport slave (
      input  scan_code, scan_valid,
      output data_out, next, done, caps_state
   );
endinterface

// File: rtl/ps2_ascii_decoder_scancode_lut.sv
// Combinational set-2 make code to ASCII lookup for letters, digits,
// space and (optionally) backspace.
module scancode_lut
   import ps2_ascii_decoder_pkg::*;
#(
   parameter bit EMIT_BACKSPACE = 1'b1
) (
   input  logic [7:0] code,
   input  logic       upper,
   output logic [7:0] ascii,
   output logic       is_char
);

   // Index 31 / 15 mark "not a letter" / "not a digit".
   logic [4:0] letter_idx;
   logic [3:0] digit_idx;

   always_comb begin
      letter_idx = 5'd31;
      case (code)
         8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;
         8'h21: letter_idx = 5'd2;   8'h23: letter_idx = 5'd3;
         8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
         8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;
         8'h43: letter_idx = 5'd8;   8'h3B: letter_idx = 5'd9;
         8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
         8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;
         8'h44: letter_idx = 5'd14;  8'h4D: letter_idx = 5'd15;
         8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
         8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;
         8'h3C: letter_idx = 5'd20;  8'h2A: letter_idx = 5'd21;
         8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
         8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
         default: letter_idx = 5'd31;
      endcase
   end

   always_comb begin
      digit_idx = 4'd15;
      case (code)
         8'h45: digit_idx = 4'd0;  8'h16: digit_idx = 4'd1;
         8'h1E: digit_idx = 4'd2;  8'h26: digit_idx = 4'd3;
         8'h25: digit_idx = 4'd4;  8'h2E: digit_idx = 4'd5;
         8'h36: digit_idx = 4'd6;  8'h3D: digit_idx = 4'd7;
         8'h3E: digit_idx = 4'd8;  8'h46: digit_idx = 4'd9;
         default: digit_idx = 4'd15;
      endcase
   end

   always_comb begin
      ascii   = '0;
      is_char = 1'b0;
      if (letter_idx != 5'd31) begin
         ascii   = letter_ascii(letter_idx, upper);
         is_char = 1'b1;
      end else if (digit_idx != 4'd15) begin
         ascii   = 8'h30 + {4'b0000, digit_idx};
         is_char = 1'b1;
      end else if (code == SC_SPACE) begin
         ascii   = ASCII_SPACE;
         is_char = 1'b1;
      end else if (EMIT_BACKSPACE && code == SC_BKSP) begin
         ascii   = ASCII_BS;
         is_char = 1'b1;
      end
   end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-byte to ASCII decoder: prefix FSM, shift/caps tracking
// and registered character/enter strobes.
module ps2_ascii_decoder
   import ps2_ascii_decoder_pkg::*;
#(
   parameter bit CAPS_ENABLE    = 1'b1,
   parameter bit EMIT_BACKSPACE = 1'b1
) (
   input  logic                Clk,
   input  logic                Reset,
   ps2_ascii_decoder_if.slave  bus
);

   state_e     state_q, state_d;
   logic       lshift_q, lshift_d;
   logic       rshift_q, rshift_d;
   logic       caps_q, caps_d;
   logic [7:0] data_out_q, data_out_d;
   logic       next_q, next_d;
   logic       done_q, done_d;

   logic [7:0] lut_ascii;
   logic       lut_is_char;

   scancode_lut #(
      .EMIT_BACKSPACE (EMIT_BACKSPACE)
   ) u_lut (
      .code    (bus.scan_code),
      .upper   ((lshift_q | rshift_q) ^ caps_q),
      .ascii   (lut_ascii),
      .is_char (lut_is_char)
   );

   always_comb begin
      state_d    = state_q;
      lshift_d   = lshift_q;
      rshift_d   = rshift_q;
      caps_d     = caps_q;
      data_out_d = data_out_q;
      next_d     = 1'b0;
      done_d     = 1'b0;
      if (bus.scan_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.scan_code == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (bus.scan_code == SC_BREAK) begin
                  state_d = ST_BRK;
               end else if (bus.scan_code == SC_LSHIFT) begin
                  lshift_d = 1'b1;
               end else if (bus.scan_code == SC_RSHIFT) begin
                  rshift_d = 1'b1;
               end else if (bus.scan_code == SC_CAPS) begin
                  if (CAPS_ENABLE) caps_d = ~caps_q;
               end else if (bus.scan_code == SC_ENTER) begin
                  done_d = 1'b1;
               end else if (lut_is_char) begin
                  data_out_d = lut_ascii;
                  next_d     = 1'b1;
               end
            end
            ST_EXT: begin
               if (bus.scan_code == SC_BREAK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  done_d  = (bus.scan_code == SC_ENTER);
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (bus.scan_code == SC_LSHIFT) lshift_d = 1'b0;
               if (bus.scan_code == SC_RSHIFT) rshift_d = 1'b0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         lshift_q   <= 1'b0;
         rshift_q   <= 1'b0;
         caps_q     <= 1'b0;
         data_out_q <= '0;
         next_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lshift_q   <= lshift_d;
         rshift_q   <= rshift_d;
         caps_q     <= caps_d;
         data_out_q <= data_out_d;
         next_q     <= next_d;
         done_q     <= done_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.next       = next_q;
   assign bus.done       = done_q;
   assign bus.caps_state = caps_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Self-checking bench: directed key sequences plus random byte streams,
// checked every cycle against a keyboard-level reference model.
module tb_ps2_ascii_decoder;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   ps2_ascii_decoder_if bus ();

   ps2_ascii_decoder #(
      .CAPS_ENABLE    (1'b1),
      .EMIT_BACKSPACE (1'b1)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: keyboard-level view of prefixes, shift keys and caps lock
   logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};

   bit         m_ext, m_brk, m_lsh, m_rsh, m_caps;
   bit         m_next, m_done;
   logic [7:0] m_data;

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_caps = 0;
      m_next = 0; m_done = 0; m_data = 8'h00;
   endtask

   task automatic model_make(input logic [7:0] c);
      bit upper;
      upper = (m_lsh || m_rsh) != m_caps;
      if (c == 8'h12) m_lsh = 1;
      else if (c == 8'h59) m_rsh = 1;
      else if (c == 8'h58) m_caps = !m_caps;
      else if (c == 8'h5A) m_done = 1;
      else if (c == 8'h29) begin m_next = 1; m_data = 8'h20; end
      else if (c == 8'h66) begin m_next = 1; m_data = 8'h08; end
      else begin
         for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) begin
               m_next = 1;
               m_data = 8'(int'(upper ? "A" : "a") + i);
            end
         for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) begin
               m_next = 1;
               m_data = 8'(int'("0") + i);
            end
      end
   endtask

   task automatic model_step(input bit v, input logic [7:0] c);
      m_next = 0; m_done = 0;
      if (!v) return;
      if (m_ext && m_brk) begin
         m_ext = 0; m_brk = 0;
      end else if (m_brk) begin
         if (c == 8'h12) m_lsh = 0;
         if (c == 8'h59) m_rsh = 0;
         m_brk = 0;
      end else if (m_ext) begin
         if (c == 8'hF0) m_brk = 1;
         else begin
            if (c == 8'h5A) m_done = 1;
            m_ext = 0;
         end
      end else if (c == 8'hE0) m_ext = 1;
      else if (c == 8'hF0) m_brk = 1;
      else model_make(c);
   endtask

   task automatic cycle(input bit v, input logic [7:0] c, input bit rst);
      @(negedge Clk);
      Reset = rst;
      bus.scan_valid = v;
      bus.scan_code = v ? c : 8'(scanrand());
      @(posedge Clk);
      if (rst) model_reset(); else model_step(v, c);
      #1;
      check("next", {7'b0, bus.next}, {7'b0, m_next});
      check("done", {7'b0, bus.done}, {7'b0, m_done});
      check("data_out", bus.data_out, m_data);
      check("caps_state", {7'b0, bus.caps_state}, {7'b0, m_caps});
   endtask

   function automatic int unsigned scanrand();
      return $urandom_range(255, 0);
   endfunction

   task automatic key(input logic [7:0] c);
      cycle(1'b1, c, 1'b0);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
   endtask

   function automatic logic [7:0] pick_code();
      int unsigned r;
      r = $urandom_range(99, 0);
      if (r < 35) return letter_codes[$urandom_range(25, 0)];
      if (r < 45) return digit_codes[$urandom_range(9, 0)];
      if (r < 55) return 8'hF0;
      if (r < 60) return 8'hE0;
      if (r < 67) return ($urandom_range(1, 0) != 0) ? 8'h12 : 8'h59;
      if (r < 71) return 8'h58;
      if (r < 75) return 8'h5A;
      if (r < 79) return 8'h29;
      if (r < 83) return 8'h66;
      return 8'(scanrand());
   endfunction

   initial begin
      bus.scan_valid = 1'b0;
      bus.scan_code  = 8'h00;
      model_reset();
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      check("reset_data", bus.data_out, 8'h00);

      // Plain letter, then shifted and released
      key(8'h1C);
      check("first_a", bus.data_out, 8'h61);
      idle(1);
      key(8'h12); key(8'h1C);
      check("shift_A", bus.data_out, 8'h41);
      key(8'hF0); key(8'h12); key(8'h1C);
      check("unshift_a", bus.data_out, 8'h61);

      // Caps lock, caps with shift, caps off
      key(8'h58); key(8'h32);
      check("caps_B", bus.data_out, 8'h42);
      key(8'h59); key(8'h32);
      check("caps_shift_b", bus.data_out, 8'h62);
      key(8'hF0); key(8'h59);
      key(8'h58);
      check("caps_off", {7'b0, bus.caps_state}, 8'h00);

      // Digit, break, Enter and keypad Enter
      key(8'h16); key(8'hF0); key(8'h16); key(8'h5A);
      check("enter_done", {7'b0, bus.done}, 8'h01);
      check("enter_hold", bus.data_out, 8'h31);
      key(8'hE0); key(8'h5A);
      check("kp_enter_done", {7'b0, bus.done}, 8'h01);

      // Extended break, unmapped byte, then space
      key(8'hE0); key(8'hF0); key(8'h1C); key(8'h0E); key(8'h29);
      check("space", bus.data_out, 8'h20);
      key(8'h66);
      check("bksp", bus.data_out, 8'h08);

      // Reset discards a pending break prefix
      key(8'hF0);
      cycle(1'b0, 8'h00, 1'b1);
      key(8'h1C);
      check("post_reset_a", bus.data_out, 8'h61);
      key(8'h32);
      check("b2b_b", bus.data_out, 8'h62);

      // Random streams, mostly back-to-back, with occasional reset
      for (int unsigned i = 0; i < 3000; i++) begin
         if ($urandom_range(299, 0) == 0) cycle(1'b0, 8'h00, 1'b1);
         else if ($urandom_range(3, 0) == 0) cycle(1'b0, 8'h00, 1'b0);
         else cycle(1'b1, pick_code(), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
